// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access FSM, branch resolve, MEM/WB register
// Loads/stores wait in ACCESS for dmem_ack (or a timeout) while stalling the upstream pipeline.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_write_reg,
  input  logic        i_write_back,
  input  logic        i_branch,
  input  logic [31:0] i_ALU_output,
  input  logic [31:0] i_readData2,
  input  logic [31:0] i_next,
  input  logic        i_ALU_zero_flag,
  input  logic [4:0]  i_rt_or_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        flush,
  output logic        o_valid,
  output logic        o_write_reg,
  output logic        o_write_back,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_ALU_output,
  output logic [4:0]  o_rt_or_rd,
  output logic        o_mem_err
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_cnt;
  logic        w_mem_op;
  logic        w_timeout;
  logic        w_done;

  assign w_mem_op  = i_mem_read | i_mem_write;
  assign w_timeout = (r_state == S_ACCESS) && !dmem_ack && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_done    = (r_state == S_ACCESS) && (dmem_ack || w_timeout);

  assign pc_src        = i_branch & i_ALU_zero_flag & (r_state == S_IDLE) & ~w_mem_op;
  assign flush         = pc_src;
  assign branch_target = i_next;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          stall        = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_done) w_next_state = S_IDLE;
        else        stall        = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control inputs are frozen by stall, so the completing edge can take them straight from EX/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 8'd0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= 32'd0;
      dmem_wdata   <= 32'd0;
      o_valid      <= 1'b0;
      o_write_reg  <= 1'b0;
      o_write_back <= 1'b0;
      o_mem_data   <= 32'd0;
      o_ALU_output <= 32'd0;
      o_rt_or_rd   <= 5'd0;
      o_mem_err    <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_write_reg  <= 1'b0;
      o_write_back <= 1'b0;
      o_mem_data   <= 32'd0;
      o_ALU_output <= 32'd0;
      o_rt_or_rd   <= 5'd0;
      if (r_state == S_IDLE) begin
        if (w_mem_op) begin
          dmem_req   <= 1'b1;
          dmem_we    <= i_mem_write;
          dmem_addr  <= i_ALU_output;
          dmem_wdata <= i_readData2;
          r_cnt      <= 8'd0;
          if (i_mem_read && i_mem_write) o_mem_err <= 1'b1;
        end else begin
          o_valid      <= 1'b1;
          o_write_reg  <= i_write_reg;
          o_write_back <= i_write_back;
          o_ALU_output <= i_ALU_output;
          o_rt_or_rd   <= i_rt_or_rd;
        end
      end else if (w_done) begin
        dmem_req     <= 1'b0;
        o_valid      <= 1'b1;
        o_write_reg  <= i_write_reg;
        o_write_back <= i_write_back;
        o_ALU_output <= i_ALU_output;
        o_rt_or_rd   <= i_rt_or_rd;
        o_mem_data   <= (dmem_ack && !dmem_we) ? dmem_rdata : 32'd0;
        if (w_timeout) o_mem_err <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage (TIMEOUT_CYCLES = 4)
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_read, i_mem_write, i_write_reg, i_write_back, i_branch;
  logic [31:0] i_ALU_output, i_readData2, i_next;
  logic        i_ALU_zero_flag;
  logic [4:0]  i_rt_or_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src, flush;
  logic [31:0] branch_target;
  logic        o_valid, o_write_reg, o_write_back;
  logic [31:0] o_mem_data, o_ALU_output;
  logic [4:0]  o_rt_or_rd;
  logic        o_mem_err;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_write_reg(i_write_reg),
    .i_write_back(i_write_back), .i_branch(i_branch), .i_ALU_output(i_ALU_output),
    .i_readData2(i_readData2), .i_next(i_next), .i_ALU_zero_flag(i_ALU_zero_flag),
    .i_rt_or_rd(i_rt_or_rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .flush(flush), .o_valid(o_valid), .o_write_reg(o_write_reg),
    .o_write_back(o_write_back), .o_mem_data(o_mem_data), .o_ALU_output(o_ALU_output),
    .o_rt_or_rd(o_rt_or_rd), .o_mem_err(o_mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        wb;
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   req_rises = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic wb, input logic [31:0] md,
                      input logic [31:0] alu, input logic [4:0] rd);
    exp_t e;
    e.wr = wr; e.wb = wb; e.md = md; e.alu = alu; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (dmem_req && !prev_req) req_rises++;
    prev_req = dmem_req;
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(o_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write_reg",  32'(o_write_reg),  32'(e.wr));
        chk("sb_write_back", 32'(o_write_back), 32'(e.wb));
        chk("sb_mem_data",   o_mem_data,        e.md);
        chk("sb_alu",        o_ALU_output,      e.alu);
        chk("sb_rd",         32'(o_rt_or_rd),   32'(e.rd));
      end
    end
  endtask

  task automatic set_in(input logic rd_en, input logic wr_en, input logic wr, input logic wb,
                        input logic br, input logic zero, input logic [31:0] alu,
                        input logic [31:0] d2, input logic [31:0] nxt, input logic [4:0] rd);
    i_mem_read = rd_en; i_mem_write = wr_en; i_write_reg = wr; i_write_back = wb;
    i_branch = br; i_ALU_zero_flag = zero; i_ALU_output = alu; i_readData2 = d2;
    i_next = nxt; i_rt_or_rd = rd;
  endtask

  // Non-memory instruction: one cycle in MEM, no stall.
  task automatic issue_alu(input logic wr, input logic wb, input logic [31:0] alu,
                           input logic [4:0] rd);
    set_in(1'b0, 1'b0, wr, wb, 1'b0, 1'b0, alu, 32'd0, 32'd0, rd);
    push(wr, wb, 32'd0, alu, rd);
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    tick();
  endtask

  // ack_k = 0 means the memory never answers and the timeout completes the access.
  task automatic do_mem(input string tag, input logic rd_en, input logic wr_en, input logic wr,
                        input logic wb, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int ack_k, input logic [31:0] rdata,
                        input logic [31:0] exp_md, input logic exp_we, input int exp_access);
    int stall_cycles = 0;
    int access_cycles = 0;
    int rises0 = req_rises;
    bit done = 0;
    set_in(rd_en, wr_en, wr, wb, 1'b1, 1'b1, addr, wd, 32'h0, rd);
    push(wr, wb, exp_md, addr, rd);
    #1;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
    chk({tag, "_pc_src_blocked"}, 32'(pc_src), 32'd0);
    if (stall) stall_cycles++;
    tick();
    for (int c = 1; c <= 20 && !done; c++) begin
      access_cycles++;
      chk({tag, "_req"},   32'(dmem_req), 32'd1);
      chk({tag, "_addr"},  dmem_addr,     addr);
      chk({tag, "_we"},    32'(dmem_we),  32'(exp_we));
      if (exp_we) chk({tag, "_wdata"}, dmem_wdata, wd);
      chk({tag, "_bubble"}, 32'(o_valid), 32'd0);
      if (c == ack_k) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
        #1;
        chk({tag, "_ack_stall"}, 32'(stall), 32'd0);
        done = 1;
      end else if (ack_k == 0 && c == TO) begin
        #1;
        chk({tag, "_timeout_stall"}, 32'(stall), 32'd0);
        done = 1;
      end
      if (stall) stall_cycles++;
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_access_cycles"}, 32'(access_cycles), 32'(exp_access));
    chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_access));
    chk({tag, "_req_count"}, 32'(req_rises - rises0), 32'd1);
    chk({tag, "_req_dropped"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    chk("rst_req",   32'(dmem_req),  32'd0);
    chk("rst_valid", 32'(o_valid),   32'd0);
    chk("rst_err",   32'(o_mem_err), 32'd0);
    chk("rst_alu",   o_ALU_output,   32'd0);
    chk("rst_addr",  dmem_addr,      32'd0);
    rst = 1'b0;

    issue_alu(1'b1, 1'b0, 32'h0000_00AA, 5'd5);

    do_mem("load", 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF,
           32'hDEADBEEF, 1'b0, 3);
    chk("load_err", 32'(o_mem_err), 32'd0);

    do_mem("store", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1234, 5'd3, 1, 32'hFFFF_FFFF,
           32'h0, 1'b1, 1);
    chk("store_err", 32'(o_mem_err), 32'd0);

    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h400, 5'd0);
    push(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("br_pc_src", 32'(pc_src), 32'd1);
    chk("br_flush",  32'(flush),  32'd1);
    chk("br_target", branch_target, 32'h400);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h400, 5'd0);
    push(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("br_nz_pc_src", 32'(pc_src), 32'd0);
    chk("br_nz_flush",  32'(flush),  32'd0);
    tick();

    do_mem("timeout", 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd9, 0, 32'h0,
           32'h0, 1'b0, TO);
    chk("timeout_err", 32'(o_mem_err), 32'd1);
    issue_alu(1'b1, 1'b1, 32'h55, 5'd2);
    chk("err_sticky", 32'(o_mem_err), 32'd1);

    // Reset in the 2nd ACCESS cycle, then an ack that must be ignored in IDLE.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 5'd4);
    tick(); tick();
    chk("mid_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_req",   32'(dmem_req),  32'd0);
    chk("mid_valid", 32'(o_valid),   32'd0);
    chk("mid_err",   32'(o_mem_err), 32'd0);
    chk("mid_md",    o_mem_data,     32'd0);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    push(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("idle_ack_stall", 32'(stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_req", 32'(dmem_req), 32'd0);

    do_mem("illegal", 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h77, 5'd1, 2, 32'h1111_2222,
           32'h0, 1'b1, 2);
    chk("illegal_err", 32'(o_mem_err), 32'd1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM pipeline register and the WB stage. It consumes the EX/MEM outputs, runs loads and stores against the data memory over a request/acknowledge handshake with variable latency, and resolves branches. While an access is outstanding it stalls the upstream pipeline. Its registered outputs form the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, maximum number of ACCESS-state cycles to wait for `dmem_ack` before the access is abandoned (range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_mem_read, i_mem_write, i_write_reg, i_write_back, i_branch  in  1 each  control bits from EX/MEM.
- i_ALU_output  in  32  effective address, or the ALU result for non-memory instructions.
- i_readData2  in  32  store data.
- i_next  in  32  branch target, (PC+4)+(imm<<2).
- i_ALU_zero_flag  in  1  branch condition.
- i_rt_or_rd  in  5  destination register; the low 5 bits of the EX/MEM field.
- dmem_req  out  1  registered memory request.
- dmem_we  out  1  registered; 1 = store.
- dmem_addr, dmem_wdata  out  32  registered; held stable while `dmem_req` = 1.
- dmem_rdata  in  32  load data; valid in the cycle `dmem_ack` = 1.
- dmem_ack  in  1  one-cycle completion pulse from the memory.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- pc_src  out  1  combinational; 1 = take the branch.
- branch_target  out  32  combinational; equals `i_next`.
- flush  out  1  combinational; equals `pc_src`; clears IF/ID and ID/EX.
- o_valid, o_write_reg, o_write_back  out  1 each  MEM/WB register.
- o_mem_data, o_ALU_output  out  32  MEM/WB register.
- o_rt_or_rd  out  5  MEM/WB register.
- o_mem_err  out  1  sticky error flag.

## Operation
- Memory op pending: `mem_op = i_mem_read | i_mem_write`.
- FSM has two states, IDLE and ACCESS.
- IDLE, `mem_op` = 1:
  - stall = 1.
  - On the next edge, move to ACCESS; load `dmem_req` = 1, `dmem_we` = `i_mem_write`, `dmem_addr` = `i_ALU_output`, `dmem_wdata` = `i_readData2`.
  - Clear the wait counter.
  - MEM/WB loads a bubble.
- IDLE, `mem_op` = 0:
  - stall = 0.
  - MEM/WB loads the instruction: o_valid = 1, o_mem_data = 0, other fields copied from the inputs.
- ACCESS, `dmem_ack` = 0:
  - stall = 1; the counter increments; MEM/WB loads a bubble.
- ACCESS, `dmem_ack` = 1:
  - stall = 0.
  - On the next edge: return to IDLE; `dmem_req` = 0; MEM/WB loads the instruction with o_mem_data = `dmem_rdata` for a load, 0 for a store.
- Timeout: in ACCESS, when counter == TIMEOUT_CYCLES-1 and `dmem_ack` = 0:
  - Treated as completion with rdata = 0.
  - o_mem_err set.
  - stall = 0 in that cycle.
- Bubble: o_valid = 0, o_write_reg = 0, o_write_back = 0. Data fields are don't-care but load 0.
- Branch: `pc_src = i_branch & i_ALU_zero_flag & (state == IDLE) & ~mem_op`.
- Illegal control, `i_mem_read & i_mem_write` both 1:
  - Executed as a store.
  - o_mem_err set.
- o_mem_err clears only on rst.
- `dmem_ack` while in IDLE is ignored.

## Timing
- Reset: state = IDLE; every registered output = 0, including `dmem_req` and o_mem_err.
- Reset mid-access: `dmem_req` drops at the reset edge. A later ack is ignored.
- Non-memory instruction: 1 cycle in MEM; no stall.
- Memory instruction with ack in ACCESS cycle k (k ≥ 1; the first ACCESS cycle is k = 1):
  - Resident k+1 cycles.
  - stall high for k cycles.
  - The result appears on MEM/WB one edge after the ack cycle.
- Stall is low in the ack cycle. EX/MEM therefore advances on the same edge MEM/WB captures, and the next instruction is not re-issued.
- `dmem_addr`, `dmem_wdata` and `dmem_we` are constant from the edge that raises `dmem_req` to the edge that drops it.
- `pc_src` and `flush` are valid in the cycle the branch is resident in MEM; the PC loads `branch_target` on that edge.

## Test plan
- ALU instruction: write_reg = 1, ALU_output = 0x0000_00AA, rt_or_rd = 5 -> stall stays 0; next cycle o_valid = 1, o_ALU_output = 0xAA, o_rt_or_rd = 5.
- Load from 0x100, ack 3 cycles after req, rdata = 0xDEADBEEF -> stall high 3 cycles; dmem_addr = 0x100 throughout; o_mem_data = 0xDEADBEEF; o_write_back = 1; exactly one request issued.
- Store: addr 0x20, readData2 = 0x1234 -> dmem_we = 1, dmem_wdata = 0x1234; ack in the first ACCESS cycle -> 2-cycle residency; o_write_reg = 0.
- Branch with zero = 1, next = 0x400 -> pc_src = flush = 1 and branch_target = 0x400 in the same cycle. Repeat with zero = 0 -> pc_src = 0.
- No ack, TIMEOUT_CYCLES = 4 -> request held 4 cycles, then o_mem_err = 1 and o_mem_data = 0; pipeline resumes.
- rst asserted in the 2nd ACCESS cycle, ack pulsed the following cycle -> dmem_req = 0 and MEM/WB outputs = 0 after the reset edge; the ack causes no MEM/WB load.
